pll_lock_reset_seq: RTL and testbench

//  Power-up and lock supervisor for the fabric CCC/PLL. Drives the PLL power-down pin and watches PLL lock.

---
 rtl/pll_lock_reset_seq_pkg.sv | 28 ++
 rtl/pll_lock_reset_seq_sync_2ff.sv | 27 ++
 rtl/pll_lock_reset_seq.sv | 188 ++++++++++++++++++
 tb/tb_pll_lock_reset_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pll_lock_reset_seq_pkg.sv
// Shared definitions for the PLL lock / fabric reset supervisor.
//   pll_state_t    : sequencer states, PWRDN is the reset state
//   LOCK_LOSS_MAX  : saturation value of the lock-loss counter
//   cnt_w_fits()   : elaboration-time check that the shared timer is wide
//                    enough for every programmed cycle count
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PWRDN     = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        FAULT     = 3'd4
    } pll_state_t;

    localparam logic [7:0] LOCK_LOSS_MAX = 8'hFF;

    // The timer only ever needs to reach (count - 1), so a count of exactly
    // 2**cnt_w still fits.
    function automatic bit cnt_w_fits(input int cnt_w, input int pwrdn_cycles,
                                      input int lock_timeout, input int stable_cycles);
        longint lim;
        lim = longint'(1) << cnt_w;
        return (longint'(pwrdn_cycles) <= lim) && (longint'(lock_timeout) <= lim)
            && (longint'(stable_cycles) <= lim);
    endfunction

endpackage

// File: rtl/pll_lock_reset_seq_sync_2ff.sv
// Generic two-flop synchronizer with asynchronous active-low reset.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears both stages to 0
//   d     : asynchronous input
//   q     : synchronized output, two clk edges behind d
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_reset_seq.sv
// Power-up and lock supervisor for the fabric PLL. Powers the PLL up, waits
// for lock to hold continuously for STABLE_CYCLES, then releases the fabric
// reset. Lock loss in RUN re-asserts the fabric reset and power-cycles the
// PLL; lock timeouts are retried up to MAX_RETRIES before a sticky fault.
// Runs on the free-running reference oscillator, never on the PLL output.
//   clk             : free-running reference clock
//   rst_n           : asynchronous active-low reset
//   enable          : 1 = run the sequence, 0 = hold PLL down and fabric in reset
//   pll_lock        : raw PLL lock, asynchronous to clk
//   pll_powerdown_n : to PLL, 0 = powered down
//   fabric_reset_n  : active-low reset for PLL-clocked logic
//   ready           : high in RUN only
//   fault           : sticky, retries exhausted
//   retry_cnt       : failed lock attempts since last RUN or enable low
//   lock_loss_cnt   : lock losses seen in RUN, saturating at 255
module pll_lock_reset_seq
    import pll_seq_pkg::*;
#(
    parameter int PWRDN_CYCLES  = 16,
    parameter int LOCK_TIMEOUT  = 65535,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 3,
    parameter int CNT_W         = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       enable,
    input  logic       pll_lock,
    output logic       pll_powerdown_n,
    output logic       fabric_reset_n,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [7:0] lock_loss_cnt
);

    localparam logic [CNT_W-1:0] PWRDN_LAST   = CNT_W'(PWRDN_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_LIMIT  = 2'(MAX_RETRIES);

    if (!cnt_w_fits(CNT_W, PWRDN_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES)) begin : g_bad_cnt_w
        $error("pll_lock_reset_seq: CNT_W=%0d is too narrow for the programmed cycle counts", CNT_W);
    end
    if (PWRDN_CYCLES < 2 || MAX_RETRIES < 1 || MAX_RETRIES > 3) begin : g_bad_params
        $error("pll_lock_reset_seq: PWRDN_CYCLES must be >= 2 and MAX_RETRIES within 1..3");
    end

    pll_state_t       state;
    pll_state_t       state_nxt;
    logic [CNT_W-1:0] timer;
    logic [CNT_W-1:0] timer_nxt;
    logic [1:0]       retry_nxt;
    logic [1:0]       retry_inc;
    logic [7:0]       lock_loss_nxt;
    logic             lock_s;
    logic             pd_nxt;
    logic             frst_nxt;
    logic             ready_nxt;
    logic             fault_nxt;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_lock),
        .q     (lock_s)
    );

    // State register. Outputs are registered from the next-state decode so
    // they switch on the same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state           <= PWRDN;
            timer           <= '0;
            retry_cnt       <= '0;
            lock_loss_cnt   <= '0;
            pll_powerdown_n <= 1'b0;
            fabric_reset_n  <= 1'b0;
            ready           <= 1'b0;
            fault           <= 1'b0;
        end else begin
            state           <= state_nxt;
            timer           <= timer_nxt;
            retry_cnt       <= retry_nxt;
            lock_loss_cnt   <= lock_loss_nxt;
            pll_powerdown_n <= pd_nxt;
            fabric_reset_n  <= frst_nxt;
            ready           <= ready_nxt;
            fault           <= fault_nxt;
        end
    end

    // Next-state logic. enable low overrides every transition. A lock that
    // arrives on the timeout cycle wins because it is tested first.
    always_comb begin
        state_nxt     = state;
        timer_nxt     = timer;
        retry_nxt     = retry_cnt;
        lock_loss_nxt = lock_loss_cnt;
        retry_inc     = retry_cnt + 2'd1;

        if (!enable) begin
            state_nxt = PWRDN;
            timer_nxt = '0;
            retry_nxt = '0;
        end else begin
            case (state)
                PWRDN: begin
                    if (timer == PWRDN_LAST) begin
                        state_nxt = WAIT_LOCK;
                        timer_nxt = '0;
                    end else begin
                        timer_nxt = timer + CNT_W'(1);
                    end
                end
                WAIT_LOCK: begin
                    if (lock_s) begin
                        state_nxt = STABLE;
                        timer_nxt = '0;
                    end else if (timer == TIMEOUT_LAST) begin
                        retry_nxt = retry_inc;
                        timer_nxt = '0;
                        state_nxt = (retry_inc == RETRY_LIMIT) ? FAULT : PWRDN;
                    end else begin
                        timer_nxt = timer + CNT_W'(1);
                    end
                end
                STABLE: begin
                    // Any dropout restarts both the stable count and the
                    // lock timeout without charging a retry.
                    if (!lock_s) begin
                        state_nxt = WAIT_LOCK;
                        timer_nxt = '0;
                    end else if (timer == STABLE_LAST) begin
                        state_nxt = RUN;
                        timer_nxt = '0;
                        retry_nxt = '0;
                    end else begin
                        timer_nxt = timer + CNT_W'(1);
                    end
                end
                RUN: begin
                    if (!lock_s) begin
                        state_nxt = PWRDN;
                        timer_nxt = '0;
                        if (lock_loss_cnt != LOCK_LOSS_MAX) begin
                            lock_loss_nxt = lock_loss_cnt + 8'd1;
                        end
                    end
                end
                FAULT: begin
                    state_nxt = FAULT;
                end
                default: begin
                    state_nxt = PWRDN;
                    timer_nxt = '0;
                end
            endcase
        end
    end

    // Output decode from the next state. Only RUN raises the fabric reset,
    // and RUN always powers the PLL, so the fabric is never released while
    // the PLL is powered down.
    always_comb begin
        pd_nxt    = 1'b0;
        frst_nxt  = 1'b0;
        ready_nxt = 1'b0;
        fault_nxt = 1'b0;
        case (state_nxt)
            WAIT_LOCK, STABLE: begin
                pd_nxt = 1'b1;
            end
            RUN: begin
                pd_nxt    = 1'b1;
                frst_nxt  = 1'b1;
                ready_nxt = 1'b1;
            end
            FAULT: begin
                fault_nxt = 1'b1;
            end
            default: begin
                pd_nxt = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_pll_lock_reset_seq.sv
// Testbench for pll_lock_reset_seq with small cycle counts
// (PWRDN_CYCLES=4, LOCK_TIMEOUT=32, STABLE_CYCLES=8, MAX_RETRIES=2).
// The stimulus process pushes cycle-stamped expectations into a scoreboard
// queue; the monitor samples outputs on every falling edge and retires the
// entries due on that cycle.
module tb_pll_lock_reset_seq;

    localparam int PWRDN_CYCLES  = 4;
    localparam int LOCK_TIMEOUT  = 32;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int CNT_W         = 8;

    // Output vector layout: {pd, frst, ready, fault, retry[1:0], loss[7:0]}
    localparam logic [13:0] M_PD  = 14'h2000;
    localparam logic [13:0] M_FR  = 14'h1000;
    localparam logic [13:0] M_RD  = 14'h0800;
    localparam logic [13:0] M_FT  = 14'h0400;
    localparam logic [13:0] M_RC  = 14'h0300;
    localparam logic [13:0] M_LL  = 14'h00FF;
    localparam logic [13:0] M_ALL = 14'h3FFF;

    typedef struct {
        int          cyc;
        logic [13:0] mask;
        logic [13:0] val;
        string       name;
    } exp_t;

    exp_t sb[$];

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic       pll_lock;
    logic       pll_powerdown_n;
    logic       fabric_reset_n;
    logic       ready;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [7:0] lock_loss_cnt;

    int cyc = 0;
    int total = 0;
    int bad = 0;
    bit finish_req = 1'b0;

    pll_lock_reset_seq #(
        .PWRDN_CYCLES  (PWRDN_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (CNT_W)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .enable          (enable),
        .pll_lock        (pll_lock),
        .pll_powerdown_n (pll_powerdown_n),
        .fabric_reset_n  (fabric_reset_n),
        .ready           (ready),
        .fault           (fault),
        .retry_cnt       (retry_cnt),
        .lock_loss_cnt   (lock_loss_cnt)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [13:0] outv(input int pd, input int fr, input int rd,
                                         input int ft, input int rc, input int ll);
        return {pd[0], fr[0], rd[0], ft[0], rc[1:0], ll[7:0]};
    endfunction

    task automatic expect_at(input int at, input logic [13:0] mask,
                             input logic [13:0] val, input string name);
        exp_t e;
        e.cyc  = at;
        e.mask = mask;
        e.val  = val;
        e.name = name;
        sb.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Monitor: retires due expectations, flags overdue ones, and checks that
    // the fabric is never released with the PLL powered down.
    always @(negedge clk) begin : monitor
        logic [13:0] obs;
        exp_t        keep[$];
        obs = {pll_powerdown_n, fabric_reset_n, ready, fault, retry_cnt, lock_loss_cnt};
        keep.delete();
        foreach (sb[i]) begin
            if (sb[i].cyc == cyc) begin
                total++;
                if ((obs & sb[i].mask) !== (sb[i].val & sb[i].mask)) begin
                    bad++;
                    $display("[TB] FAIL %s at cycle %0d: got %h, required %h (mask %h)",
                             sb[i].name, cyc, obs & sb[i].mask, sb[i].val & sb[i].mask, sb[i].mask);
                end
            end else if (sb[i].cyc < cyc) begin
                total++;
                bad++;
                $display("[TB] FAIL %s: due at cycle %0d but missed (now %0d)", sb[i].name, sb[i].cyc, cyc);
            end else begin
                keep.push_back(sb[i]);
            end
        end
        sb = keep;

        total++;
        if (fabric_reset_n === 1'b1 && pll_powerdown_n !== 1'b1) begin
            bad++;
            $display("[TB] FAIL fabric_while_pd at cycle %0d: got fabric_reset_n=1 pll_powerdown_n=%b, required pll_powerdown_n=1",
                     cyc, pll_powerdown_n);
        end

        if (finish_req) begin
            foreach (sb[i]) begin
                total++;
                bad++;
                $display("[TB] FAIL %s: never checked (due cycle %0d)", sb[i].name, sb[i].cyc);
            end
            $display("test done: total=%0d bad=%0d", total, bad);
            $finish;
        end
    end

    initial begin : watchdog
        #600000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        int c0, l, d, r, e, g, t, f, s, ll;
        rst_n    = 1'b0;
        enable   = 1'b0;
        pll_lock = 1'b0;
        tick(3);
        expect_at(cyc, M_ALL, '0, "reset_state");
        tick(1);

        // Normal lock: power-down released at edge 4, lock 10 cycles later.
        $display("[TB] normal lock");
        c0 = cyc;
        rst_n  = 1'b1;
        enable = 1'b1;
        expect_at(c0 + 3, M_PD | M_FR, outv(0, 0, 0, 0, 0, 0), "pd_low_before_edge4");
        expect_at(c0 + 4, M_PD | M_FR | M_RD, outv(1, 0, 0, 0, 0, 0), "pd_rises_edge4");
        tick(14);
        l = cyc;
        pll_lock = 1'b1;
        expect_at(l + 10, M_PD | M_FR | M_RD, outv(1, 0, 0, 0, 0, 0), "release_not_early");
        expect_at(l + 11, M_ALL, outv(1, 1, 1, 0, 0, 0), "release_after_lock");
        tick(13);

        // Lock loss in RUN: reset 3 edges after drop, 4-cycle power-down, relock.
        $display("[TB] lock loss in run");
        d = cyc;
        pll_lock = 1'b0;
        expect_at(d + 2, M_FR | M_LL, outv(0, 1, 0, 0, 0, 0), "run_holds_2_edges");
        expect_at(d + 3, M_ALL, outv(0, 0, 0, 0, 0, 1), "lock_loss_reset");
        expect_at(d + 6, M_PD, outv(0, 0, 0, 0, 0, 0), "loss_pwrdn_4_cycles");
        expect_at(d + 7, M_PD | M_FR, outv(1, 0, 0, 0, 0, 0), "loss_pd_released");
        tick(7);
        r = cyc;
        pll_lock = 1'b1;
        expect_at(r + 11, M_ALL, outv(1, 1, 1, 0, 0, 1), "relock_run");
        tick(13);

        // Glitch in STABLE: enable low restarts the sequence, then lock drops
        // for 3 cycles after 5 stable cycles.
        $display("[TB] lock glitch in stable");
        e = cyc;
        enable   = 1'b0;
        pll_lock = 1'b0;
        expect_at(e + 1, M_ALL, outv(0, 0, 0, 0, 0, 1), "enable_low_pwrdn");
        tick(1);
        enable = 1'b1;
        tick(4);
        g = cyc;
        expect_at(g, M_PD, outv(1, 0, 0, 0, 0, 0), "glitch_pd_up");
        pll_lock = 1'b1;
        tick(5);
        pll_lock = 1'b0;
        expect_at(g + 11, M_FR | M_RD, outv(0, 0, 0, 0, 0, 0), "glitch_holds_reset");
        tick(3);
        pll_lock = 1'b1;
        expect_at(g + 18, M_PD | M_FR, outv(1, 0, 0, 0, 0, 0), "glitch_not_early");
        expect_at(g + 19, M_ALL, outv(1, 1, 1, 0, 0, 1), "glitch_release");
        tick(11);

        // Timeout retries with lock held low, then sticky fault.
        $display("[TB] timeout retries");
        t = cyc;
        enable   = 1'b0;
        pll_lock = 1'b0;
        tick(1);
        enable = 1'b1;
        expect_at(t + 36, M_PD | M_FT | M_RC, outv(1, 0, 0, 0, 0, 0), "before_timeout1");
        expect_at(t + 37, M_ALL, outv(0, 0, 0, 0, 1, 1), "timeout1");
        expect_at(t + 40, M_PD | M_RC, outv(0, 0, 0, 0, 1, 0), "retry_pwrdn_4_cycles");
        expect_at(t + 41, M_PD | M_RC, outv(1, 0, 0, 0, 1, 0), "retry_wait");
        expect_at(t + 72, M_PD | M_FT | M_RC, outv(1, 0, 0, 0, 1, 0), "before_timeout2");
        expect_at(t + 73, M_ALL, outv(0, 0, 0, 1, 2, 1), "fault_entry");
        tick(74);
        pll_lock = 1'b1;
        expect_at(t + 90, M_ALL, outv(0, 0, 0, 1, 2, 1), "fault_sticky");
        tick(15);

        // enable low clears the fault on the next edge.
        $display("[TB] enable clears fault, async reset mid-stable");
        f = cyc;
        enable = 1'b0;
        expect_at(f + 1, M_ALL, outv(0, 0, 0, 0, 0, 1), "enable_clears_fault");
        tick(1);
        enable = 1'b1;
        expect_at(f + 5, M_PD | M_FR, outv(1, 0, 0, 0, 0, 0), "wait_after_fault");
        expect_at(f + 8, M_PD | M_FR | M_RD, outv(1, 0, 0, 0, 0, 0), "mid_stable");
        tick(8);
        // Reset asserted between edges and sampled before the next edge.
        rst_n = 1'b0;
        expect_at(cyc, M_ALL, '0, "async_reset");
        tick(2);

        // Saturation: 260 lock losses in RUN.
        $display("[TB] lock loss saturation");
        s = cyc;
        rst_n = 1'b1;
        expect_at(s + 12, M_RD | M_LL, outv(0, 0, 0, 0, 0, 0), "run_not_early_after_reset");
        expect_at(s + 13, M_ALL, outv(1, 1, 1, 0, 0, 0), "run_after_reset");
        tick(13);
        for (int i = 0; i < 260; i++) begin
            ll = (i + 1 > 255) ? 255 : i + 1;
            d = cyc;
            pll_lock = 1'b0;
            if (i < 3 || i >= 252) begin
                expect_at(d + 3, M_FR | M_LL, outv(0, 0, 0, 0, 0, ll), "sat_loss");
                expect_at(d + 16, M_RD | M_LL, outv(0, 0, 1, 0, 0, ll), "sat_relock");
            end
            tick(3);
            pll_lock = 1'b1;
            tick(13);
        end

        tick(20);
        finish_req = 1'b1;
        tick(5);
    end

endmodule
